// File: rtl/axi_burst_slave_mem_pkg.sv
// Shared response codes and channel FSM state encodings for the AXI-style burst slave.
package axi_burst_slave_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_DATA = 2'd1
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

endpackage

// File: rtl/axi_burst_slave_mem_ctr.sv
// Per-channel burst tracker: word-address incrementer, beat counter and last-beat compare.
module axi_burst_slave_mem_ctr #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  start_len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [LEN_W-1:0] beat;
  logic [LEN_W-1:0] len_q;

  // The address wraps naturally at 2^ADDR_W; the beat never passes len_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr  <= '0;
      beat  <= '0;
      len_q <= '0;
    end else if (load) begin
      addr  <= start_addr;
      beat  <= '0;
      len_q <= start_len;
    end else if (advance) begin
      addr <= addr + ADDR_W'(1);
      beat <= beat + LEN_W'(1);
    end
  end

  assign last = (beat == len_q);

endmodule

// File: rtl/axi_burst_slave_mem.sv
// AXI-style INCR burst slave over a DEPTH-word register memory with independent read and write FSMs.
module axi_burst_slave_mem
  import axi_burst_slave_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [ID_W-1:0]   ARID,
  input  logic [LEN_W-1:0]  ARLEN,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [ID_W-1:0]   RID,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [ID_W-1:0]   AWID,
  input  logic [LEN_W-1:0]  AWLEN,
  input  logic              WVALID,
  output logic              WREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              WLAST,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic [1:0]        r_fsm,
  output logic [1:0]        w_fsm
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);

  // Handshake rule on every channel: a transfer happens on the rising edge where
  // VALID && READY; a VALID source keeps its payload stable until that edge.

  r_state_e r_state, r_next;
  w_state_e w_state, w_next;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ID_W-1:0]   r_id, w_id;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic              r_last, w_last;
  logic              r_load, r_adv, w_load, w_adv;
  logic              r_in, w_in, w_we, w_err, w_set_err, w_clr_err;

  assign r_in = ({1'b0, r_addr} < DEPTH_A);
  assign w_in = ({1'b0, w_addr} < DEPTH_A);

  axi_burst_slave_mem_ctr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_r_ctr (
    .clk(clk), .rst(rst), .load(r_load), .advance(r_adv),
    .start_addr(ARADDR), .start_len(ARLEN), .addr(r_addr), .last(r_last)
  );

  axi_burst_slave_mem_ctr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_w_ctr (
    .clk(clk), .rst(rst), .load(w_load), .advance(w_adv),
    .start_addr(AWADDR), .start_len(AWLEN), .addr(w_addr), .last(w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
      r_id    <= '0;
      w_id    <= '0;
      w_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
      if (r_load) r_id <= ARID;
      if (w_load) w_id <= AWID;
      if (w_clr_err)      w_err <= 1'b0;
      else if (w_set_err) w_err <= 1'b1;
      if (w_we) mem[w_addr[IDX_W-1:0]] <= WDATA;
    end
  end

  // Read channel; RDATA is a combinational read, so a same-edge write is seen one cycle later.
  always_comb begin
    r_next  = r_state;
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    RDATA   = '0;
    RID     = '0;
    RRESP   = RESP_OKAY;
    RLAST   = 1'b0;
    r_load  = 1'b0;
    r_adv   = 1'b0;
    if (!rst) begin
      unique case (r_state)
        R_IDLE: begin
          ARREADY = 1'b1;
          if (ARVALID) begin
            r_load = 1'b1;
            r_next = R_DATA;
          end
        end
        R_DATA: begin
          RVALID = 1'b1;
          RID    = r_id;
          RLAST  = r_last;
          RRESP  = r_in ? RESP_OKAY : RESP_SLVERR;
          RDATA  = r_in ? mem[r_addr[IDX_W-1:0]] : '0;
          if (RREADY) begin
            r_adv = 1'b1;
            if (r_last) r_next = R_IDLE;
          end
        end
        default: r_next = R_IDLE;
      endcase
    end
  end

  // Write channel; the burst closes on WLAST or the programmed final beat, whichever comes first.
  always_comb begin
    w_next    = w_state;
    AWREADY   = 1'b0;
    WREADY    = 1'b0;
    BVALID    = 1'b0;
    BID       = '0;
    BRESP     = RESP_OKAY;
    w_load    = 1'b0;
    w_adv     = 1'b0;
    w_we      = 1'b0;
    w_set_err = 1'b0;
    w_clr_err = 1'b0;
    if (!rst) begin
      unique case (w_state)
        W_IDLE: begin
          AWREADY = 1'b1;
          if (AWVALID) begin
            w_load = 1'b1;
            w_next = W_DATA;
          end
        end
        W_DATA: begin
          WREADY = 1'b1;
          if (WVALID) begin
            w_adv = 1'b1;
            w_we  = w_in;
            if (!w_in || (WLAST != w_last)) w_set_err = 1'b1;
            if (WLAST || w_last) w_next = W_RESP;
          end
        end
        W_RESP: begin
          BVALID = 1'b1;
          BID    = w_id;
          BRESP  = w_err ? RESP_SLVERR : RESP_OKAY;
          if (BREADY) begin
            w_clr_err = 1'b1;
            w_next    = W_IDLE;
          end
        end
        default: w_next = W_IDLE;
      endcase
    end
  end

  assign r_fsm = rst ? 2'b00 : r_state;
  assign w_fsm = rst ? 2'b00 : w_state;

endmodule

// File: tb/tb_axi_burst_slave_mem.sv
// Bench for axi_burst_slave_mem: table-driven bursts, hand-written corner sequences and random traffic vs a memory model.
module tb_axi_burst_slave_mem;

  logic       clk = 1'b0;
  logic       rst;
  logic       ARVALID, ARREADY, RVALID, RREADY, RLAST;
  logic [7:0] ARADDR, RDATA;
  logic [3:0] ARID, ARLEN, RID;
  logic [1:0] RRESP;
  logic       AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic [7:0] AWADDR, WDATA;
  logic [3:0] AWID, AWLEN, BID;
  logic [1:0] BRESP;
  logic [1:0] r_fsm, w_fsm;

  axi_burst_slave_mem dut (
    .clk(clk), .rst(rst),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARID(ARID), .ARLEN(ARLEN),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RID(RID), .RRESP(RRESP), .RLAST(RLAST),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWID(AWID), .AWLEN(AWLEN),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
    .r_fsm(r_fsm), .w_fsm(w_fsm)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: a plain array of the 16 memory words.
  logic [7:0] model_mem [16];
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] addr;
    logic [3:0] len;
    logic [3:0] id;
    int         wlast_at;
    logic [1:0] bresp;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_bresp(input logic [7:0] addr, input logic [3:0] len, input int wlast_at);
    int  nb;
    bit  err;
    err = (wlast_at != int'(len));
    nb  = ((wlast_at < int'(len)) ? wlast_at : int'(len)) + 1;
    for (int b = 0; b < nb; b++)
      if (((int'(addr) + b) % 256) >= 16) err = 1'b1;
    return err ? 2'b10 : 2'b00;
  endfunction

  // Driver: one write burst; WLAST is raised on beat wlast_at (>len means never).
  task automatic do_write(input logic [7:0] addr, input logic [3:0] len, input logic [3:0] id,
                          input int wlast_at, input bit seq_data, input logic [1:0] exp_bresp);
    int nb, a, k;
    logic [7:0] d;
    nb = ((wlast_at < int'(len)) ? wlast_at : int'(len)) + 1;
    @(negedge clk);
    AWVALID = 1'b1; AWADDR = addr; AWLEN = len; AWID = id;
    #1 check("awready", AWREADY, 1);
    @(negedge clk);
    AWVALID = 1'b0;
    for (int b = 0; b < nb; b++) begin
      if (!seq_data && $urandom_range(0, 3) == 0) begin
        WVALID = 1'b0; WLAST = 1'b0;
        @(negedge clk);
      end
      d = seq_data ? 8'(b + 1) : 8'($urandom_range(0, 255));
      WVALID = 1'b1; WDATA = d; WLAST = (b == wlast_at);
      #1 check("wready", WREADY, 1);
      @(negedge clk);
      a = (int'(addr) + b) % 256;
      if (a < 16) model_mem[a] = d;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    #1;
    check("bvalid", BVALID, 1);
    check("bid", BID, id);
    check("bresp", BRESP, exp_bresp);
    k = seq_data ? 0 : $urandom_range(0, 2);
    repeat (k) begin
      @(negedge clk);
      #1;
      check("bvalid_hold", BVALID, 1);
      check("bresp_hold", BRESP, exp_bresp);
    end
    BREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0;
    #1;
    check("bvalid_done", BVALID, 0);
    check("awready_again", AWREADY, 1);
  endtask

  // Driver + checker: one read burst. mode 0 always ready, 1 random, 2 pattern 1,0,0,1.
  task automatic do_read(input logic [7:0] addr, input logic [3:0] len, input logic [3:0] id, input int mode);
    int beat, cyc, a;
    logic [7:0] ed;
    logic [1:0] er;
    @(negedge clk);
    ARVALID = 1'b1; ARADDR = addr; ARLEN = len; ARID = id;
    #1 check("arready", ARREADY, 1);
    @(negedge clk);
    ARVALID = 1'b0;
    beat = 0;
    cyc  = 0;
    while (beat <= int'(len) && cyc < 200) begin
      case (mode)
        0:       RREADY = 1'b1;
        1:       RREADY = 1'($urandom_range(0, 1));
        default: RREADY = (cyc % 4 == 0) || (cyc % 4 == 3);
      endcase
      a  = (int'(addr) + beat) % 256;
      ed = (a < 16) ? model_mem[a] : 8'h00;
      er = (a < 16) ? 2'b00 : 2'b10;
      #1;
      check("rvalid", RVALID, 1);
      check("rdata", RDATA, ed);
      check("rresp", RRESP, er);
      check("rlast", RLAST, beat == int'(len));
      check("rid", RID, id);
      @(negedge clk);
      if (RREADY) beat++;
      cyc++;
    end
    check("r_beats", beat, int'(len) + 1);
    RREADY = 1'b0;
    #1;
    check("rvalid_done", RVALID, 0);
    check("arready_again", ARREADY, 1);
  endtask

  initial begin
    logic [7:0] old_v, new_v;
    logic [7:0] ra;
    logic [3:0] rl;
    int         wl;

    vecs[0] = '{8'd14,  4'd3,  4'd7, 3,  2'b10};
    vecs[1] = '{8'd4,   4'd3,  4'd9, 1,  2'b10};
    vecs[2] = '{8'd4,   4'd3,  4'd9, 3,  2'b00};
    vecs[3] = '{8'd254, 4'd3,  4'd1, 3,  2'b10};
    vecs[4] = '{8'd10,  4'd1,  4'd2, 16, 2'b10};
    vecs[5] = '{8'd0,   4'd15, 4'd4, 15, 2'b00};
    vecs[6] = '{8'd15,  4'd0,  4'd11, 0, 2'b00};

    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    rst = 1'b1;
    ARVALID = 0; ARADDR = 0; ARID = 0; ARLEN = 0; RREADY = 0;
    AWVALID = 0; AWADDR = 0; AWID = 0; AWLEN = 0;
    WVALID = 0; WDATA = 0; WLAST = 0; BREADY = 0;

    // Reset: every output low while rst is high, both address channels ready after.
    #1;
    check("rst_arready", ARREADY, 0);
    check("rst_awready", AWREADY, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_bvalid", BVALID, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_arready", ARREADY, 1);
    check("post_rst_awready", AWREADY, 1);
    check("post_rst_wready", WREADY, 0);
    check("post_rst_bvalid", BVALID, 0);

    // Basic write 1,2,3 then read back with free-running and stalled RREADY.
    do_write(8'd1, 4'd2, 4'd3, 2, 1'b1, 2'b00);
    do_read(8'd1, 4'd2, 4'd5, 0);
    do_read(8'd1, 4'd2, 4'd5, 2);

    // Table of write bursts, each followed by a readback.
    for (int i = 0; i < 7; i++) begin
      do_write(vecs[i].addr, vecs[i].len, vecs[i].id, vecs[i].wlast_at, 1'b0, vecs[i].bresp);
      do_read(vecs[i].addr, vecs[i].len, vecs[i].id, 1);
    end
    do_read(8'd16, 4'd0, 4'd8, 0);

    // Same-word read and write on one edge: old value first, new value next cycle.
    old_v = model_mem[5];
    new_v = old_v ^ 8'h5a;
    @(negedge clk);
    ARVALID = 1; ARADDR = 8'd5; ARLEN = 4'd1; ARID = 4'd6;
    AWVALID = 1; AWADDR = 8'd5; AWLEN = 4'd0; AWID = 4'd2;
    RREADY = 0;
    @(negedge clk);
    ARVALID = 0; AWVALID = 0;
    WVALID = 1; WDATA = new_v; WLAST = 1;
    #1 check("rw_old", RDATA, old_v);
    @(negedge clk);
    WVALID = 0; WLAST = 0;
    model_mem[5] = new_v;
    #1;
    check("rw_new", RDATA, new_v);
    check("rw_bvalid", BVALID, 1);
    check("rw_bresp", BRESP, 2'b00);
    BREADY = 1; RREADY = 1;
    @(negedge clk);
    BREADY = 0;
    #1;
    check("rw_beat2", RDATA, model_mem[6]);
    check("rw_rlast", RLAST, 1);
    @(negedge clk);
    RREADY = 0;
    #1 check("rw_rdone", RVALID, 0);

    // Random traffic against the model.
    for (int n = 0; n < 40; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 15));
      rl = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0:       wl = (rl > 0) ? $urandom_range(0, int'(rl) - 1) : 0;
        1:       wl = 16;
        default: wl = int'(rl);
      endcase
      do_write(ra, rl, 4'($urandom_range(0, 15)), wl, 1'b0, model_bresp(ra, rl, wl));
      ra = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom_range(0, 20));
      do_read(ra, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1);
    end

    // Reset during the second beat of a read burst.
    @(negedge clk);
    ARVALID = 1; ARADDR = 8'd0; ARLEN = 4'd3; ARID = 4'd12;
    @(negedge clk);
    ARVALID = 0; RREADY = 1;
    #1 check("mid_beat0", RDATA, model_mem[0]);
    @(negedge clk);
    rst = 1; RREADY = 0;
    #1;
    check("mid_rst_rvalid", RVALID, 0);
    check("mid_rst_arready", ARREADY, 0);
    check("mid_rst_rdata", RDATA, 0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    #1;
    check("mid_post_arready", ARREADY, 1);
    check("mid_post_rvalid", RVALID, 0);
    do_read(8'd0, 4'd15, 4'd1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
